regfile_wr_arbiter: RTL

Write-port arbiter and sequencer for the 32-entry register file of the multicycle MIPS datapath. Two writeback sources compete for the register file's single write port: the ALU-result path (A) and the memory-load path (B). The block grants them round-robin, registers the winning address/data into a one-entry output stage, and drives a one-hot write-enable vector to the register array. It honours a hold from the main control FSM and suppresses architectural writes to register 0.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_wr_arbiter_dec.sv | 19 +
 rtl/regfile_wr_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter: geometry,
// FSM encodings and the hard-wired zero register address.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        STALL = 2'd2
    } wr_state_t;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    // Round-robin tie break: B wins a tie only if A was granted last.
    function automatic logic pick_b(input logic a_v, input logic b_v, input logic last_b);
        return b_v & (~a_v | ~last_b);
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_dec.sv
// Purely combinational binary-to-one-hot decoder for register write enables.
// Gating (issue, hold, zero register) is applied by the parent.
module reg_onehot_dec
    import regfile_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int N_OUT = NUM_REGS
) (
    input  logic [AW-1:0]    addr,
    output logic [N_OUT-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_dec
            assign onehot[gi] = (addr == AW'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter between the ALU (A) and load (B) writeback paths,
// feeding a one-entry output stage that drives the register-file write port.
module regfile_wr_arbiter #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_valid,
    input  logic [ADDR_W-1:0]    a_addr,
    input  logic [WIDTH-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADDR_W-1:0]    b_addr,
    input  logic [WIDTH-1:0]     b_data,
    output logic                 b_ready,
    input  logic                 hold,
    output logic [2**ADDR_W-1:0] wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [WIDTH-1:0]     wr_data,
    output logic                 busy,
    output logic [7:0]           wr_count
);

    import regfile_pkg::*;

    localparam int NREG = 2**ADDR_W;

    wr_state_t          state_reg, state_next;
    logic               last_b_reg, last_b_next;
    logic [ADDR_W-1:0]  wr_addr_reg;
    logic [WIDTH-1:0]   wr_data_reg;
    logic [7:0]         wr_count_reg;

    logic               grant_a, grant_b;
    logic               can_accept, accept;
    logic               fire, fire_nonzero;
    logic [NREG-1:0]    dec_onehot;

    reg_onehot_dec #(
        .AW    (ADDR_W),
        .N_OUT (NREG)
    ) u_dec (
        .addr   (wr_addr_reg),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_next   = state_reg;
        last_b_next  = last_b_reg;
        grant_b      = pick_b(a_valid, b_valid, last_b_reg);
        grant_a      = a_valid & ~grant_b;
        // rst_n gates readiness so nothing is handshaken while reset is held.
        can_accept   = rst_n & ((state_reg == IDLE) | ((state_reg == ISSUE) & ~hold));
        accept       = can_accept & (a_valid | b_valid);
        // A full stage issues in any cycle without hold, including leaving STALL.
        fire         = (state_reg != IDLE) & ~hold;
        fire_nonzero = fire & (wr_addr_reg != ADDR_W'(REG_ZERO));

        case (state_reg)
            IDLE: begin
                if (accept) state_next = ISSUE;
            end
            ISSUE: begin
                if (hold)        state_next = STALL;
                else if (accept) state_next = ISSUE;
                else             state_next = IDLE;
            end
            STALL: begin
                // The held write drains on the first hold-free cycle.
                if (!hold) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (accept) last_b_next = grant_b;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_b_reg   <= 1'b1;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
            wr_count_reg <= '0;
        end else begin
            state_reg  <= state_next;
            last_b_reg <= last_b_next;
            if (accept) begin
                wr_addr_reg <= grant_b ? b_addr : a_addr;
                wr_data_reg <= grant_b ? b_data : a_data;
            end
            if (fire_nonzero) wr_count_reg <= wr_count_reg + 8'd1;
        end
    end

    assign a_ready  = can_accept & grant_a;
    assign b_ready  = can_accept & grant_b;
    assign wr_en    = fire_nonzero ? dec_onehot : '0;
    assign wr_addr  = wr_addr_reg;
    assign wr_data  = wr_data_reg;
    assign busy     = (state_reg != IDLE);
    assign wr_count = wr_count_reg;

endmodule
